// File: rtl/mem_cmd_rr_arbiter.sv
// mem_cmd_rr_arbiter: round-robin sharing of one memory cmd/status port among NUM_REQ requesters, in-order tag FIFO routes status back; MEM_ARB_STATS_EN adds grant/stall counters
module mem_cmd_rr_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = 64,
  parameter int LEN_W           = 23,
  parameter int STS_W           = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_REQ-1:0]            s_cmd_valid,
  output logic [NUM_REQ-1:0]            s_cmd_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     s_cmd_addr,
  input  logic [NUM_REQ*LEN_W-1:0]      s_cmd_len,
  output logic                          m_cmd_valid,
  input  logic                          m_cmd_ready,
  output logic [ADDR_W-1:0]             m_cmd_addr,
  output logic [LEN_W-1:0]              m_cmd_len,
  input  logic                          s_sts_valid,
  output logic                          s_sts_ready,
  input  logic [STS_W-1:0]              s_sts_data,
  output logic [NUM_REQ-1:0]            m_sts_valid,
  input  logic [NUM_REQ-1:0]            m_sts_ready,
  output logic [STS_W-1:0]              m_sts_data,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
`ifdef MEM_ARB_STATS_EN
  output logic                          sts_orphan,
  output logic [NUM_REQ*32-1:0]         grant_cnt,
  output logic [31:0]                   stall_cycles
`else
  output logic                          sts_orphan
`endif
);
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  logic [TAG_W-1:0]     r_rr_ptr, w_sel, w_gidx, w_head, w_rr_next;
  logic [TAG_W:0]       w_sum;
  logic [2*NUM_REQ-1:0] w_rot;
  logic                 w_grant, w_empty, w_pop;
  logic                 r_m_cmd_valid, r_orphan;
  logic [ADDR_W-1:0]    r_addr;
  logic [LEN_W-1:0]     r_len;
  logic [PTR_W-1:0]     r_wptr, r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic [TAG_W-1:0]     r_tags [MAX_OUTSTANDING];
  // rotate valids so bit k is requester (rr_ptr+k) mod NUM_REQ; lowest k wins
  always_comb begin
    w_rot = {s_cmd_valid, s_cmd_valid} >> r_rr_ptr;
    w_sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_rot[k]) w_sel = TAG_W'(k);
  end
  assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_sel};
  assign w_gidx     = (w_sum >= (TAG_W+1)'(NUM_REQ)) ? TAG_W'(w_sum - (TAG_W+1)'(NUM_REQ)) : TAG_W'(w_sum);
  assign w_rr_next  = (w_gidx == TAG_W'(NUM_REQ - 1)) ? '0 : w_gidx + TAG_W'(1);
  assign w_grant    = !areset && (!r_m_cmd_valid || m_cmd_ready) &&
                      (r_count < CNT_W'(MAX_OUTSTANDING)) && (|s_cmd_valid);
  assign s_cmd_ready = w_grant ? NUM_REQ'(1) << w_gidx : '0;
  assign w_empty     = (r_count == '0);
  assign w_head      = r_tags[r_rptr];
  assign m_sts_valid = (s_sts_valid && !w_empty) ? NUM_REQ'(1) << w_head : '0;
  assign s_sts_ready = m_sts_ready[w_head] && !w_empty;
  assign m_sts_data  = s_sts_data;
  assign w_pop       = s_sts_valid && s_sts_ready;
  assign m_cmd_valid = r_m_cmd_valid;
  assign m_cmd_addr  = r_addr;
  assign m_cmd_len   = r_len;
  assign outstanding = r_count;
  assign sts_orphan  = r_orphan;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_m_cmd_valid <= 1'b0;
      r_addr        <= '0;
      r_len         <= '0;
      r_rr_ptr      <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_orphan      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_m_cmd_valid <= 1'b1;
        r_addr        <= ADDR_W'(s_cmd_addr >> (ADDR_W * int'(w_gidx)));
        r_len         <= LEN_W'(s_cmd_len >> (LEN_W * int'(w_gidx)));
        r_rr_ptr      <= w_rr_next;
      end else if (m_cmd_ready) begin
        r_m_cmd_valid <= 1'b0;
      end
      if (w_grant) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_grant) - CNT_W'(w_pop);
      if (s_sts_valid && w_empty) r_orphan <= 1'b1;
    end
  end
  always_ff @(posedge aclk)
    if (w_grant) r_tags[r_wptr] <= w_gidx;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stall;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [31:0] r_cnt;
    always_ff @(posedge aclk or posedge areset)
      if (areset) r_cnt <= '0;
      else if (w_grant && w_gidx == TAG_W'(i) && r_cnt != '1) r_cnt <= r_cnt + 32'd1;
    assign grant_cnt[i*32 +: 32] = r_cnt;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) r_stall <= '0;
    else if ((|s_cmd_valid) && !w_grant && r_stall != '1) r_stall <= r_stall + 32'd1;
  assign stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_mem_cmd_rr_arbiter.sv
// tb_mem_cmd_rr_arbiter: directed scenarios plus random traffic against a queue-based reference model
module tb_mem_cmd_rr_arbiter;
  localparam int N = 2, AW = 64, LW = 23, SW = 8, MO = 16, OW = $clog2(MO) + 1;
  logic aclk = 1'b0, areset = 1'b1;
  always #5 aclk = ~aclk;
  logic [N-1:0]    s_cmd_valid = '0, s_cmd_ready, m_sts_valid, m_sts_ready = '0;
  logic [N*AW-1:0] s_cmd_addr = '0;
  logic [N*LW-1:0] s_cmd_len = '0;
  logic            m_cmd_valid, m_cmd_ready = 1'b0, s_sts_valid = 1'b0, s_sts_ready, sts_orphan;
  logic [AW-1:0]   m_cmd_addr;
  logic [LW-1:0]   m_cmd_len;
  logic [SW-1:0]   s_sts_data = '0, m_sts_data;
  logic [OW-1:0]   outstanding;
`ifdef MEM_ARB_STATS_EN
  logic [N*32-1:0] grant_cnt;
  logic [31:0]     stall_cycles;
`endif
  mem_cmd_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .STS_W(SW), .MAX_OUTSTANDING(MO)) dut (
    .aclk(aclk), .areset(areset),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len),
    .s_sts_valid(s_sts_valid), .s_sts_ready(s_sts_ready), .s_sts_data(s_sts_data),
    .m_sts_valid(m_sts_valid), .m_sts_ready(m_sts_ready), .m_sts_data(m_sts_data),
    .outstanding(outstanding),
`ifdef MEM_ARB_STATS_EN
    .grant_cnt(grant_cnt), .stall_cycles(stall_cycles),
`endif
    .sts_orphan(sts_orphan));
  int checks = 0, errors = 0;
  bit mvalid, morph;
  logic [AW-1:0] maddr;
  logic [LW-1:0] mlen;
  int rr, last_g;
  int tq[$];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    mvalid = 0; morph = 0; maddr = '0; mlen = '0; rr = 0; last_g = -1;
    tq.delete();
  endtask
  // check every output against the model, then advance model and DUT one cycle
  task automatic step();
    int g;
    bit ok, empty, essr;
    int head;
    logic [N-1:0] er, esv;
    #1;
    ok = (!mvalid || m_cmd_ready) && tq.size() < MO && s_cmd_valid != '0;
    g = 0;
    for (int k = N - 1; k >= 0; k--)
      if (((s_cmd_valid >> ((rr + k) % N)) & N'(1)) != '0) g = (rr + k) % N;
    er = ok ? N'(1) << g : '0;
    empty = tq.size() == 0;
    head = empty ? 0 : tq[0];
    esv = (s_sts_valid && !empty) ? N'(1) << head : '0;
    essr = !empty && (((m_sts_ready >> head) & N'(1)) != '0);
    chk("s_cmd_ready", s_cmd_ready, er);
    chk("m_cmd_valid", m_cmd_valid, mvalid);
    chk("m_cmd_addr", m_cmd_addr, maddr);
    chk("m_cmd_len", m_cmd_len, mlen);
    chk("outstanding", outstanding, tq.size());
    chk("sts_orphan", sts_orphan, morph);
    chk("m_sts_valid", m_sts_valid, esv);
    chk("s_sts_ready", s_sts_ready, essr);
    chk("m_sts_data", m_sts_data, s_sts_data);
    last_g = ok ? g : -1;
    if (s_sts_valid && empty) morph = 1;
    if (s_sts_valid && essr) void'(tq.pop_front());
    if (ok) begin
      mvalid = 1;
      maddr = AW'(s_cmd_addr >> (g * AW));
      mlen = LW'(s_cmd_len >> (g * LW));
      tq.push_back(g);
      rr = (g + 1) % N;
    end else if (m_cmd_ready) mvalid = 0;
    @(posedge aclk);
    @(negedge aclk);
  endtask
  task automatic drain();
    s_cmd_valid = '0; m_cmd_ready = 1; m_sts_ready = '1;
    for (int i = 0; i < 200 && (tq.size() != 0 || mvalid); i++) begin
      s_sts_valid = tq.size() > 0;
      step();
    end
    s_sts_valid = 0;
    chk("drain_outstanding", outstanding, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    model_reset();
    s_cmd_valid = '1; s_sts_valid = 1;
    #1;
    chk("rst_s_cmd_ready", s_cmd_ready, 0);
    chk("rst_m_cmd_valid", m_cmd_valid, 0);
    chk("rst_m_cmd_addr", m_cmd_addr, 0);
    chk("rst_m_cmd_len", m_cmd_len, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_sts_orphan", sts_orphan, 0);
    chk("rst_m_sts_valid", m_sts_valid, 0);
    @(negedge aclk);
    areset = 0; s_sts_valid = 0;
    // fairness: both requesters always valid, status returned every cycle
    s_cmd_addr = {64'hB000, 64'hA000}; s_cmd_len = {23'd200, 23'd100};
    m_cmd_ready = 1; m_sts_ready = '1;
    for (int i = 0; i < 100; i++) begin
      s_sts_valid = tq.size() > 0;
      #1 chk("fair_alt", s_cmd_ready, (i % 2) ? 2'b10 : 2'b01);
      step();
    end
`ifdef MEM_ARB_STATS_EN
    chk("fair_cnt0", grant_cnt[31:0], 50);
    chk("fair_cnt1", grant_cnt[63:32], 50);
`endif
    drain();
    // backpressure
    s_cmd_addr = '0; s_cmd_addr[AW-1:0] = 64'h1000;
    s_cmd_len = '0; s_cmd_len[LW-1:0] = 23'd64;
    s_cmd_valid = 2'b01; m_cmd_ready = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_addr", m_cmd_addr, 64'h1000);
      chk("bp_len", m_cmd_len, 64);
      chk("bp_ready", s_cmd_ready, 0);
      step();
    end
    m_cmd_ready = 1;
    #1 chk("bp_release_grant", s_cmd_ready, 2'b01);
    step();
    drain();
    // credit limit
    s_cmd_valid = 2'b11; s_sts_valid = 0; m_cmd_ready = 1; n = 0;
    for (int i = 0; i < 20; i++) begin
      #1 if (s_cmd_ready != '0) n++;
      step();
    end
    chk("credit_issued", n, 16);
    chk("credit_outstanding", outstanding, 16);
    chk("credit_ready", s_cmd_ready, 0);
    s_sts_valid = 1; m_sts_ready = '1;
    #1 chk("credit_no_same_cycle", s_cmd_ready, 0);
    step();
    s_sts_valid = 0;
    #1 chk("credit_regrant", s_cmd_ready != '0, 1);
    step();
    drain();
    // routing: issue req1, req0, req1
    s_cmd_valid = 2'b10; step();
    s_cmd_valid = 2'b01; step();
    s_cmd_valid = 2'b10; step();
    s_cmd_valid = 2'b00;
    s_sts_valid = 1; s_sts_data = 8'h80; m_sts_ready = 2'b01;
    #1 chk("route_stall_ready", s_sts_ready, 0);
    chk("route_stall_valid", m_sts_valid, 2'b10);
    step();
    m_sts_ready = '1;
    #1 chk("route0_valid", m_sts_valid, 2'b10);
    chk("route0_data", m_sts_data, 8'h80);
    step();
    s_sts_data = 8'h81;
    #1 chk("route1_valid", m_sts_valid, 2'b01);
    chk("route1_data", m_sts_data, 8'h81);
    step();
    s_sts_data = 8'h82;
    #1 chk("route2_valid", m_sts_valid, 2'b10);
    chk("route2_data", m_sts_data, 8'h82);
    step();
    chk("route_empty", outstanding, 0);
    // orphan status
    s_sts_valid = 1;
    #1 chk("orphan_ready", s_sts_ready, 0);
    step();
    s_sts_valid = 0;
    chk("orphan_set", sts_orphan, 1);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      s_cmd_valid = N'($urandom);
      s_cmd_addr = {$urandom, $urandom, $urandom, $urandom};
      s_cmd_len = (N*LW)'({$urandom, $urandom});
      m_cmd_ready = ($urandom % 4) != 0;
      s_sts_valid = (tq.size() > 0) && ($urandom % 2 == 1);
      s_sts_data = SW'($urandom);
      m_sts_ready = N'($urandom);
      step();
    end
    chk("orphan_sticky", sts_orphan, 1);
    drain();
    // async reset mid-burst
    s_cmd_valid = 2'b11; m_cmd_ready = 1;
    for (int i = 0; i < 7; i++) step();
    chk("pre_rst_outstanding", outstanding, 7);
    chk("pre_rst_valid", m_cmd_valid, 1);
    s_sts_valid = 1;
    #2 areset = 1;
    #1 chk("arst_m_cmd_valid", m_cmd_valid, 0);
    chk("arst_outstanding", outstanding, 0);
    chk("arst_s_cmd_ready", s_cmd_ready, 0);
    chk("arst_m_sts_valid", m_sts_valid, 0);
    chk("arst_orphan", sts_orphan, 0);
    model_reset();
    @(negedge aclk);
    areset = 0; s_sts_valid = 0;
    #1 chk("post_rst_grant0", s_cmd_ready, 2'b01);
    step();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
